pipe_stall_ctrl: RTL and testbench
==================================

// Module: pipe_stall_ctrl
// PURPOSE
//   Pipeline sequencer for the IF/ID front end. Merges load-use hazard, taken-branch,
//   exception and multi-cycle-unit (MDU) busy requests into one prioritised set of
//   hold/bubble/flush/PC-select controls. Sits beside ID; drives the PC mux, IF/ID hold,
//   ID control-zeroing (bubble) and EPC capture.
// PARAMETERS
//   FLUSH_CYCLES  1   IF/ID flush cycles after a taken branch, >=1
//   EXC_DRAIN     2   cycles from exc_req to vector redirect, >=1
//   CNT_W         32  width of performance counters
// PORTS
//   clk           in   1      rising-edge clock
//   rst_n         in   1      reset; one clock; asynchronous, active-low
//   load_use      in   1      load-use hazard detected in ID
//   br_taken      in   1      branch resolved taken in ID
//   exc_req       in   1      exception raised in ID
//   mdu_busy      in   1      multi-cycle unit still computing
//   id_needs_mdu  in   1      instruction in ID needs the MDU result
//   hold_pc       out  1      PC keeps its value
//   hold_if       out  1      IF/ID register keeps its value
//   bubble_id     out  1      zero ID control word into ID/EX
//   flush_if      out  1      IF/ID register loaded with a NOP
//   pc_sel        out  2      00 sequential, 01 branch target, 10 exception vector
//   epc_we        out  1      capture EPC this cycle
//   ctrl_state    out  2      current FSM state
//   stall_cnt     out  CNT_W  stall-cycle count
//   flush_cnt     out  CNT_W  flush-cycle count
// BEHAVIOUR
//   - Outputs are combinational from (state, inputs) (Mealy); state and down-counter are registered.
//   - rst_n=0: state RUN, cnt 0, perf counters 0. All outputs forced 0 regardless of inputs.
//     Reset mid-sequence aborts it; no redirect issued.
//   - States: RUN=0, STALL=1, FLUSH=2, EXC=3. Priority in RUN:
//     exc_req > br_taken > load_use > (id_needs_mdu & mdu_busy).
//   - RUN/exc_req: epc_we=1, hold_pc=1, flush_if=1, bubble_id=1, pc_sel=00.
//     Next state EXC, cnt=EXC_DRAIN-1.
//   - EXC: hold_pc=1, flush_if=1, bubble_id=1 while cnt!=0; cnt decrements.
//     At cnt==0: pc_sel=10, hold_pc=0, flush_if=1, bubble_id=1, then go to RUN.
//     All inputs are ignored in EXC.
//   - RUN/br_taken: pc_sel=01, flush_if=1.
//     FLUSH_CYCLES==1: stay in RUN.
//     Otherwise: go to FLUSH with cnt=FLUSH_CYCLES-2.
//   - FLUSH: flush_if=1, pc_sel=00; go to RUN when cnt==0, else decrement.
//     exc_req is honoured as in RUN. br_taken and load_use are ignored.
//   - RUN/load_use: hold_pc=hold_if=bubble_id=1 for that cycle only; stay in RUN.
//     Re-evaluated every cycle.
//   - RUN/mdu wait: hold_pc=hold_if=bubble_id=1; go to STALL.
//   - STALL: same three outputs while mdu_busy=1.
//     mdu_busy=0: all outputs 0 in that same cycle, then go to RUN.
//     exc_req is honoured (takes the EXC path). br_taken and load_use are ignored.
//   - Counter widths are $clog2(max(FLUSH_CYCLES,EXC_DRAIN))+1; no wrap is possible.
// CONFIGURATION
//   PIPE_STALL_CTRL_PERF_EN defined:
//     - stall_cnt +1 on each cycle with bubble_id=1 in RUN or STALL.
//     - flush_cnt +1 on each cycle with flush_if=1.
//     - Both saturate at all-ones.
//   Undefined: stall_cnt/flush_cnt ports remain present, tied to 0, no counter flops.
// STRUCTURE
//   pipe_stall_ctrl_pkg:
//     - state enum
//     - PC_SEQ/PC_BR/PC_EXC pc_sel encodings
//   Sub-module pipe_stall_sat_cnt (parameterised CNT_W saturating counter, async reset),
//   instanced twice under the macro.
// TESTING
//   1. rst_n=0 with exc_req=br_taken=load_use=1 -> every output 0.
//      Release -> ctrl_state=0.
//   2. load_use=1 at cycle T only -> hold_pc=hold_if=bubble_id=1 at T, all 0 at T+1,
//      ctrl_state=0; PERF_EN: stall_cnt=1.
//   3. FLUSH_CYCLES=2, br_taken at T -> T: pc_sel=01, flush_if=1;
//      T+1: ctrl_state=2, flush_if=1, pc_sel=00; T+2: flush_if=0, ctrl_state=0.
//   4. EXC_DRAIN=2, exc_req at T -> T: epc_we=1, hold_pc=1; T+1: ctrl_state=3, hold_pc=1;
//      T+2: pc_sel=10, hold_pc=0; T+3: ctrl_state=0.
//   5. id_needs_mdu=1, mdu_busy=1 for 3 cycles then 0 -> hold_pc=1 for 3 cycles, 0 on the 4th.
//      Repeat with exc_req in stall cycle 2 -> epc_we=1 there, ctrl_state=3 next.
//   6. exc_req, br_taken and load_use all 1 in RUN -> epc_we=1, pc_sel=00, no branch redirect.
//      Assert rst_n=0 at T+1 -> outputs 0 immediately, ctrl_state=0.

Source files
------------

// File: rtl/pipe_stall_ctrl_pkg.sv
// Shared types for the IF/ID pipeline sequencer: FSM state encoding and PC mux selects.
package pipe_stall_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_STALL = 2'd1,
        ST_FLUSH = 2'd2,
        ST_EXC   = 2'd3
    } state_t;

    localparam logic [1:0] PC_SEQ = 2'b00;
    localparam logic [1:0] PC_BR  = 2'b01;
    localparam logic [1:0] PC_EXC = 2'b10;

endpackage

// File: rtl/pipe_stall_sat_cnt.sv
// Saturating up-counter with async active-low reset, used for pipeline perf statistics.
module pipe_stall_sat_cnt #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc && (cnt_q != '1)) cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/pipe_stall_ctrl.sv
// IF/ID front-end sequencer: prioritises exception, branch, load-use and MDU-wait requests.
// Perf counters are built only when PIPE_STALL_CTRL_PERF_EN is defined.
//   state | meaning
//   RUN   | normal issue; per-cycle hazard evaluation
//   STALL | waiting for the MDU result
//   FLUSH | extra IF/ID flush cycles after a taken branch
//   EXC   | draining before the exception-vector redirect
module pipe_stall_ctrl
    import pipe_stall_ctrl_pkg::*;
#(
    parameter int FLUSH_CYCLES = 1,
    parameter int EXC_DRAIN    = 2,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_use,
    input  logic             br_taken,
    input  logic             exc_req,
    input  logic             mdu_busy,
    input  logic             id_needs_mdu,
    output logic             hold_pc,
    output logic             hold_if,
    output logic             bubble_id,
    output logic             flush_if,
    output logic [1:0]       pc_sel,
    output logic             epc_we,
    output logic [1:0]       ctrl_state,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int MAX_CYC = (FLUSH_CYCLES > EXC_DRAIN) ? FLUSH_CYCLES : EXC_DRAIN;
    localparam int CW      = $clog2(MAX_CYC) + 1;
    localparam logic [CW-1:0] EXC_LOAD   = CW'(EXC_DRAIN - 1);
    localparam logic [CW-1:0] FLUSH_LOAD = CW'((FLUSH_CYCLES > 1) ? FLUSH_CYCLES - 2 : 0);

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic       hold_pc_c, hold_if_c, bubble_c, flush_c, epc_c, take_exc;
    logic [1:0] pc_sel_c;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hold_pc_c = 1'b0;
        hold_if_c = 1'b0;
        bubble_c  = 1'b0;
        flush_c   = 1'b0;
        epc_c     = 1'b0;
        pc_sel_c  = PC_SEQ;
        take_exc  = 1'b0;

        case (state_q)
            ST_RUN: begin
                if (exc_req) begin
                    take_exc = 1'b1;
                end else if (br_taken) begin
                    pc_sel_c = PC_BR;
                    flush_c  = 1'b1;
                    if (FLUSH_CYCLES > 1) begin
                        state_d = ST_FLUSH;
                        cnt_d   = FLUSH_LOAD;
                    end
                end else if (load_use) begin
                    hold_pc_c = 1'b1;
                    hold_if_c = 1'b1;
                    bubble_c  = 1'b1;
                end else if (id_needs_mdu && mdu_busy) begin
                    hold_pc_c = 1'b1;
                    hold_if_c = 1'b1;
                    bubble_c  = 1'b1;
                    state_d   = ST_STALL;
                end
            end
            ST_STALL: begin
                if (exc_req) begin
                    take_exc = 1'b1;
                end else if (mdu_busy) begin
                    hold_pc_c = 1'b1;
                    hold_if_c = 1'b1;
                    bubble_c  = 1'b1;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_FLUSH: begin
                if (exc_req) begin
                    take_exc = 1'b1;
                end else begin
                    flush_c = 1'b1;
                    if (cnt_q == '0) state_d = ST_RUN;
                    else             cnt_d   = cnt_q - 1'b1;
                end
            end
            ST_EXC: begin
                flush_c  = 1'b1;
                bubble_c = 1'b1;
                if (cnt_q != '0) begin
                    hold_pc_c = 1'b1;
                    cnt_d     = cnt_q - 1'b1;
                end else begin
                    pc_sel_c = PC_EXC;
                    state_d  = ST_RUN;
                end
            end
            default: state_d = ST_RUN;
        endcase

        // Exception entry looks the same from RUN, STALL and FLUSH.
        if (take_exc) begin
            epc_c     = 1'b1;
            hold_pc_c = 1'b1;
            flush_c   = 1'b1;
            bubble_c  = 1'b1;
            pc_sel_c  = PC_SEQ;
            state_d   = ST_EXC;
            cnt_d     = EXC_LOAD;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Reset masks the Mealy outputs so no control leaks out while rst_n is low.
    assign hold_pc    = rst_n & hold_pc_c;
    assign hold_if    = rst_n & hold_if_c;
    assign bubble_id  = rst_n & bubble_c;
    assign flush_if   = rst_n & flush_c;
    assign epc_we     = rst_n & epc_c;
    assign pc_sel     = rst_n ? pc_sel_c : PC_SEQ;
    assign ctrl_state = rst_n ? state_q : ST_RUN;

`ifdef PIPE_STALL_CTRL_PERF_EN
    logic stall_inc;
    assign stall_inc = bubble_id & ((state_q == ST_RUN) | (state_q == ST_STALL));

    pipe_stall_sat_cnt #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (stall_inc),
        .cnt   (stall_cnt)
    );

    pipe_stall_sat_cnt #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (flush_if),
        .cnt   (flush_cnt)
    );
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Directed bench for pipe_stall_ctrl with FLUSH_CYCLES=2, EXC_DRAIN=2.
module tb_pipe_stall_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        load_use, br_taken, exc_req, mdu_busy, id_needs_mdu;
    logic        hold_pc, hold_if, bubble_id, flush_if, epc_we;
    logic [1:0]  pc_sel, ctrl_state;
    logic [31:0] stall_cnt, flush_cnt;

    int n_chk  = 0;
    int n_pass = 0;

    pipe_stall_ctrl #(.FLUSH_CYCLES(2), .EXC_DRAIN(2), .CNT_W(32)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .load_use     (load_use),
        .br_taken     (br_taken),
        .exc_req      (exc_req),
        .mdu_busy     (mdu_busy),
        .id_needs_mdu (id_needs_mdu),
        .hold_pc      (hold_pc),
        .hold_if      (hold_if),
        .bubble_id    (bubble_id),
        .flush_if     (flush_if),
        .pc_sel       (pc_sel),
        .epc_we       (epc_we),
        .ctrl_state   (ctrl_state),
        .stall_cnt    (stall_cnt),
        .flush_cnt    (flush_cnt)
    );

    always #5 clk = ~clk;

    // Packed view: {hold_pc, hold_if, bubble_id, flush_if, pc_sel[1:0], epc_we, ctrl_state[1:0]}
    wire [8:0] outs = {hold_pc, hold_if, bubble_id, flush_if, pc_sel, epc_we, ctrl_state};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic set_in(input logic lu, input logic bt, input logic ex,
                          input logic mb, input logic nm);
        load_use     = lu;
        br_taken     = bt;
        exc_req      = ex;
        mdu_busy     = mb;
        id_needs_mdu = nm;
    endtask

    // One clock: apply inputs, check outputs at the falling edge, advance past the rising edge.
    task automatic cyc(input string tag, input logic lu, input logic bt, input logic ex,
                       input logic mb, input logic nm, input logic [8:0] exp);
        set_in(lu, bt, ex, mb, nm);
        @(negedge clk);
        chk(tag, 32'(outs), 32'(exp));
        @(posedge clk);
        #1;
    endtask

    initial begin
        // reset with hazard inputs asserted
        rst_n = 1'b0;
        set_in(1, 1, 1, 1, 1);
        @(negedge clk);
        chk("rst_outs", 32'(outs), 32'h0);
        #2;
        rst_n = 1'b1;
        set_in(0, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        cyc("rst_release", 0, 0, 0, 0, 0, 9'b000_0_00_0_00);

        // load-use: single-cycle hold
        cyc("lu_T",  1, 0, 0, 0, 0, 9'b111_0_00_0_00);
        cyc("lu_T1", 0, 0, 0, 0, 0, 9'b000_0_00_0_00);
`ifdef PIPE_STALL_CTRL_PERF_EN
        chk("stall_cnt_lu", stall_cnt, 32'd1);
`else
        chk("stall_cnt_lu", stall_cnt, 32'd0);
`endif

        // taken branch; load_use during FLUSH is ignored
        cyc("br_T",  0, 1, 0, 0, 0, 9'b000_1_01_0_00);
        cyc("br_T1", 1, 1, 0, 0, 0, 9'b000_1_00_0_10);
        cyc("br_T2", 0, 0, 0, 0, 0, 9'b000_0_00_0_00);
`ifdef PIPE_STALL_CTRL_PERF_EN
        chk("flush_cnt_br", flush_cnt, 32'd2);
`else
        chk("flush_cnt_br", flush_cnt, 32'd0);
`endif

        // exception drain; inputs ignored in EXC
        cyc("exc_T",  0, 0, 1, 0, 0, 9'b101_1_00_1_00);
        cyc("exc_T1", 1, 1, 1, 1, 1, 9'b101_1_00_0_11);
        cyc("exc_T2", 0, 0, 0, 0, 0, 9'b001_1_10_0_11);
        cyc("exc_T3", 0, 0, 0, 0, 0, 9'b000_0_00_0_00);

        // exception during a FLUSH cycle
        cyc("fx_T",  0, 1, 0, 0, 0, 9'b000_1_01_0_00);
        cyc("fx_T1", 0, 0, 1, 0, 0, 9'b101_1_00_1_10);
        cyc("fx_T2", 0, 0, 0, 0, 0, 9'b101_1_00_0_11);
        cyc("fx_T3", 0, 0, 0, 0, 0, 9'b001_1_10_0_11);
        cyc("fx_T4", 0, 0, 0, 0, 0, 9'b000_0_00_0_00);

        // MDU wait for 3 cycles; br/load_use ignored in STALL
        cyc("mdu_c1", 0, 0, 0, 1, 1, 9'b111_0_00_0_00);
        cyc("mdu_c2", 0, 0, 0, 1, 1, 9'b111_0_00_0_01);
        cyc("mdu_c3", 1, 1, 0, 1, 1, 9'b111_0_00_0_01);
        cyc("mdu_c4", 0, 0, 0, 0, 1, 9'b000_0_00_0_01);
        cyc("mdu_c5", 0, 0, 0, 0, 0, 9'b000_0_00_0_00);

        // MDU wait interrupted by an exception
        cyc("mdx_c1", 0, 0, 0, 1, 1, 9'b111_0_00_0_00);
        cyc("mdx_c2", 0, 0, 1, 1, 1, 9'b101_1_00_1_01);
        cyc("mdx_c3", 0, 0, 0, 1, 1, 9'b101_1_00_0_11);
        cyc("mdx_c4", 0, 0, 0, 1, 1, 9'b001_1_10_0_11);
        cyc("mdx_c5", 0, 0, 0, 0, 0, 9'b000_0_00_0_00);

        // priority: exception beats branch and load-use; reset aborts the drain
        cyc("pri_T", 1, 1, 1, 0, 0, 9'b101_1_00_1_00);
        rst_n = 1'b0;
        @(negedge clk);
        chk("pri_rst", 32'(outs), 32'h0);
        chk("pri_rst_state", 32'(ctrl_state), 32'd0);
        #2;
        rst_n = 1'b1;
        set_in(0, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        cyc("pri_after", 0, 0, 0, 0, 0, 9'b000_0_00_0_00);
        chk("cnt_after_rst", stall_cnt | flush_cnt, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
